// File: rtl/cpu_obi_data_arbiter.sv
// ============================================================================
// cpu_obi_data_arbiter: two-master to one-slave OBI data arbiter with route FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_obi_data_arbiter_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cpu_obi_data_arbiter
  import cpu_obi_data_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ROUND_ROBIN     = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  m0_req_i,
  output obi_resp_t m0_resp_o,
  input  obi_req_t  m1_req_i,
  output obi_resp_t m1_resp_o,
  output obi_req_t  s_req_o,
  input  obi_resp_t s_resp_i,
  output logic      busy_o,
  output logic      err_o
);

  localparam int            PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int            CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] route_mem;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;
  logic                       rr_pref;
  logic                       lock;
  logic                       lock_idx;
  logic                       err;

  logic     full;
  logic     sel_valid;
  logic     sel_idx;
  logic     handshake;
  logic     pop;
  logic     head;
  logic     head_valid;
  obi_req_t sel_req;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full      = (count == MAX_CNT);
    sel_valid = 1'b0;
    sel_idx   = 1'b0;
    // A stalled address phase keeps its master until the slave grants it.
    if (lock) begin
      sel_valid = 1'b1;
      sel_idx   = lock_idx;
    end else if (m0_req_i.req && m1_req_i.req) begin
      sel_valid = 1'b1;
      sel_idx   = (ROUND_ROBIN != 0) ? rr_pref : 1'b0;
    end else if (m0_req_i.req) begin
      sel_valid = 1'b1;
      sel_idx   = 1'b0;
    end else if (m1_req_i.req) begin
      sel_valid = 1'b1;
      sel_idx   = 1'b1;
    end

    sel_req = sel_idx ? m1_req_i : m0_req_i;
    s_req_o = '0;
    if (sel_valid) begin
      s_req_o     = sel_req;
      s_req_o.req = sel_req.req & ~full;
    end

    handshake  = s_req_o.req & s_resp_i.gnt;
    head_valid = (count != '0);
    pop        = s_resp_i.rvalid & head_valid;
    head       = route_mem[rd_ptr];

    m0_resp_o        = '0;
    m1_resp_o        = '0;
    m0_resp_o.gnt    = handshake & ~sel_idx;
    m1_resp_o.gnt    = handshake & sel_idx;
    m0_resp_o.rvalid = pop & ~head;
    m1_resp_o.rvalid = pop & head;
    if (head_valid && !head) m0_resp_o.rdata = s_resp_i.rdata;
    if (head_valid && head)  m1_resp_o.rdata = s_resp_i.rdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      route_mem <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_pref   <= 1'b0;
      lock      <= 1'b0;
      lock_idx  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (handshake) begin
        route_mem[wr_ptr] <= sel_idx;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({handshake, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (handshake && (ROUND_ROBIN != 0)) rr_pref <= ~sel_idx;
      lock     <= s_req_o.req & ~s_resp_i.gnt;
      lock_idx <= sel_idx;
      // A response with nothing outstanding cannot be routed; flag it for good.
      if (s_resp_i.rvalid && !head_valid) err <= 1'b1;
    end
  end

  assign busy_o = (count != '0);
  assign err_o  = err;

endmodule

`default_nettype wire

// File: tb/tb_cpu_obi_data_arbiter.sv
// ============================================================================
// tb_cpu_obi_data_arbiter: directed and randomized checks against a queue model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu_obi_data_arbiter;
  import cpu_obi_data_arbiter_pkg::*;

  localparam int MAXO = 2;
  localparam int RR   = 1;

  logic      clk   = 1'b0;
  logic      rst_n = 1'b0;
  obi_req_t  m0_req, m1_req, s_req;
  obi_resp_t m0_resp, m1_resp, s_resp;
  logic      busy, err;

  int errors = 0;
  int checks = 0;

  cpu_obi_data_arbiter #(.MAX_OUTSTANDING(MAXO), .ROUND_ROBIN(RR)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .m0_req_i  (m0_req),
    .m0_resp_o (m0_resp),
    .m1_req_i  (m1_req),
    .m1_resp_o (m1_resp),
    .s_req_o   (s_req),
    .s_resp_i  (s_resp),
    .busy_o    (busy),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: outstanding ids are a queue, order of issue is order of return.
  int        q[$];
  bit        m_err, m_lock, eg0, eg1;
  int        m_lock_idx, m_pref, sel;
  bit        selv, sreq, hs, full;
  obi_req_t  cand, e_req;
  obi_resp_t e_r0, e_r1;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_err = 0; m_lock = 0; m_pref = 0; eg0 = 0; eg1 = 0;
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_m0_rvalid", m0_resp.rvalid, 0);
      chk("rst_m1_rvalid", m1_resp.rvalid, 0);
    end else begin
      full = (q.size() == MAXO);
      selv = 1; sel = 0;
      if (m_lock)                         sel = m_lock_idx;
      else if (m0_req.req && m1_req.req)  sel = (RR != 0) ? m_pref : 0;
      else if (m0_req.req)                sel = 0;
      else if (m1_req.req)                sel = 1;
      else                                selv = 0;
      cand = (sel == 1) ? m1_req : m0_req;
      sreq = selv && cand.req && !full;
      e_req = '0;
      if (selv) begin
        e_req     = cand;
        e_req.req = sreq;
      end
      hs = sreq && s_resp.gnt;
      e_r0 = '0;
      e_r1 = '0;
      e_r0.gnt = hs && (sel == 0);
      e_r1.gnt = hs && (sel == 1);
      if (q.size() > 0) begin
        if (q[0] == 0) begin e_r0.rvalid = s_resp.rvalid; e_r0.rdata = s_resp.rdata; end
        else           begin e_r1.rvalid = s_resp.rvalid; e_r1.rdata = s_resp.rdata; end
      end
      chk("s_req", s_req, e_req);
      chk("m0_resp", m0_resp, e_r0);
      chk("m1_resp", m1_resp, e_r1);
      chk("busy", busy, q.size() != 0);
      chk("err", err, m_err);

      if (s_resp.rvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else              m_err = 1;
      end
      if (hs) begin
        q.push_back(sel);
        if (RR != 0) m_pref = 1 - sel;
      end
      m_lock     = sreq && !s_resp.gnt;
      m_lock_idx = sel;
      eg0 = e_r0.gnt;
      eg1 = e_r1.gnt;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int idx, input logic req, input logic [31:0] addr);
    obi_req_t r;
    r       = '0;
    r.req   = req;
    r.be    = 4'hF;
    r.addr  = addr;
    if (idx == 0) m0_req = r; else m1_req = r;
  endtask

  task automatic drive_s(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    s_resp.gnt    = gnt;
    s_resp.rvalid = rvalid;
    s_resp.rdata  = rdata;
  endtask

  initial begin
    m0_req = '0; m1_req = '0; s_resp = '0;
    next_cycle(); next_cycle();
    @(negedge clk);
    chk("rst_sreq", s_req.req, 0);
    next_cycle();
    rst_n = 1'b1;

    // Single master read
    drive_m(0, 1, 32'h0000_1000); drive_s(1, 0, 0);
    @(negedge clk);
    chk("t1_m0_gnt", m0_resp.gnt, 1);
    chk("t1_addr", s_req.addr, 32'h0000_1000);
    chk("t1_m1_gnt", m1_resp.gnt, 0);
    next_cycle();
    drive_m(0, 0, 0); drive_s(0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_m0_rvalid", m0_resp.rvalid, 1);
    chk("t1_m0_rdata", m0_resp.rdata, 32'hDEAD_BEEF);
    chk("t1_m1_rvalid", m1_resp.rvalid, 0);
    chk("t1_busy", busy, 1);
    next_cycle();
    drive_s(0, 0, 0);
    @(negedge clk);
    chk("t1_busy_end", busy, 0);
    next_cycle();

    // Round-robin contention; pointer now prefers m1
    for (int k = 0; k < 6; k++) begin
      drive_m(0, 1, 32'h0000_00A0); drive_m(1, 1, 32'h0000_00B0);
      drive_s(1, k > 0, 32'h100 + k);
      @(negedge clk);
      chk("t2_m1_gnt", m1_resp.gnt, (k % 2) == 0);
      chk("t2_m0_gnt", m0_resp.gnt, (k % 2) == 1);
      if (k > 0) begin
        if (((k - 1) % 2) == 0) chk("t2_route_m1", {m1_resp.rvalid, m1_resp.rdata}, {1'b1, 32'h100 + k});
        else                    chk("t2_route_m0", {m0_resp.rvalid, m0_resp.rdata}, {1'b1, 32'h100 + k});
      end
      next_cycle();
    end
    drive_m(0, 0, 0); drive_m(1, 0, 0); drive_s(0, 1, 32'h200);
    @(negedge clk);
    chk("t2_drain_m0", m0_resp.rvalid, 1);
    next_cycle();

    // Lock: m1 preferred, slave stalls three cycles
    for (int k = 0; k < 3; k++) begin
      drive_m(1, 1, 32'h0000_2000); drive_m(0, 1, 32'h0000_3000); drive_s(0, 0, 0);
      @(negedge clk);
      chk("t3_lock_addr", s_req.addr, 32'h0000_2000);
      chk("t3_lock_gnt", {m0_resp.gnt, m1_resp.gnt}, 2'b00);
      next_cycle();
    end
    drive_s(1, 0, 0);
    @(negedge clk);
    chk("t3_m1_gnt", m1_resp.gnt, 1);
    chk("t3_m1_addr", s_req.addr, 32'h0000_2000);
    next_cycle();
    drive_m(1, 0, 0);
    @(negedge clk);
    chk("t3_m0_gnt", m0_resp.gnt, 1);
    chk("t3_m0_addr", s_req.addr, 32'h0000_3000);
    next_cycle();

    // Full with two outstanding: no bypass on pop
    drive_m(0, 0, 0); drive_m(1, 1, 32'h0000_4000); drive_s(1, 0, 0);
    @(negedge clk);
    chk("t4_full_req", s_req.req, 0);
    chk("t4_full_gnt", m1_resp.gnt, 0);
    next_cycle();
    drive_s(1, 1, 32'h1111_1111);
    @(negedge clk);
    chk("t4_pop_req", s_req.req, 0);
    chk("t4_pop_gnt", m1_resp.gnt, 0);
    chk("t4_pop_route", {m1_resp.rvalid, m1_resp.rdata, m0_resp.rvalid}, {1'b1, 32'h1111_1111, 1'b0});
    next_cycle();
    drive_s(1, 0, 0);
    @(negedge clk);
    chk("t4_late_gnt", {s_req.req, m1_resp.gnt}, 2'b11);
    next_cycle();

    // Simultaneous push and pop at one outstanding
    drive_m(1, 0, 0); drive_s(0, 1, 32'h5555);
    @(negedge clk);
    chk("t5_pre_pop", m0_resp.rvalid, 1);
    next_cycle();
    drive_m(0, 1, 32'h0000_5000); drive_s(1, 1, 32'h2222_2222);
    @(negedge clk);
    chk("t5_gnt", m0_resp.gnt, 1);
    chk("t5_old_head", {m1_resp.rvalid, m1_resp.rdata, m0_resp.rvalid}, {1'b1, 32'h2222_2222, 1'b0});
    next_cycle();
    drive_m(0, 0, 0); drive_s(0, 1, 32'h3333_3333);
    @(negedge clk);
    chk("t5_busy", busy, 1);
    chk("t5_new_id", {m0_resp.rvalid, m0_resp.rdata}, {1'b1, 32'h3333_3333});
    next_cycle();
    drive_s(0, 0, 0);
    @(negedge clk);
    chk("t5_idle", busy, 0);
    next_cycle();

    // Spurious rvalid, sticky error, reset clears it
    drive_s(0, 1, 32'h7777);
    @(negedge clk);
    chk("t6_no_rvalid", {m0_resp.rvalid, m1_resp.rvalid}, 2'b00);
    next_cycle();
    drive_s(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_err_sticky", err, 1);
      next_cycle();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_err_clear", err, 0);
    next_cycle();
    rst_n = 1'b1;

    // Reset while a transaction is outstanding; the late response is an error
    drive_m(0, 1, 32'h0000_6000); drive_s(1, 0, 0);
    next_cycle();
    drive_m(0, 0, 0); drive_s(0, 0, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t6_flush_busy", busy, 0);
    next_cycle();
    rst_n = 1'b1;
    drive_s(0, 1, 32'h8888);
    next_cycle();
    drive_s(0, 0, 0);
    @(negedge clk);
    chk("t6_late_err", err, 1);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // Randomized traffic; masters hold their request until granted
    for (int c = 0; c < 3000; c++) begin
      if (!m0_req.req || eg0) begin
        m0_req.req = ($urandom_range(0, 99) < 60);
        m0_req.we = 1'(($urandom) & 1); m0_req.be = 4'($urandom);
        m0_req.addr = $urandom; m0_req.wdata = $urandom;
      end
      if (!m1_req.req || eg1) begin
        m1_req.req = ($urandom_range(0, 99) < 60);
        m1_req.we = 1'(($urandom) & 1); m1_req.be = 4'($urandom);
        m1_req.addr = $urandom; m1_req.wdata = $urandom;
      end
      s_resp.gnt    = 1'($urandom_range(0, 1));
      s_resp.rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_resp.rdata  = $urandom;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_obi_data_arbiter.md
Name: cpu_obi_data_arbiter

Overview:
Two-master to one-slave OBI arbiter that shares the CPU subsystem data port (master 0, core_data_req/resp) with a second requester (master 1: debug/DMA/XIF memory path) toward a single bus slave port. It has a zero-latency address path, round-robin or fixed-priority selection, and OBI address-phase locking. An outstanding-transaction route FIFO steers each rvalid/rdata back to the master that issued the request. It sits between cpu_subsystem and the system bus crossbar.

Parameters:
MAX_OUTSTANDING, 2, depth of the route FIFO and the maximum number of granted-but-unanswered transactions (1..8).
ROUND_ROBIN, 1, 1 selects round-robin arbitration; 0 gives master 0 fixed priority.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
m0_req_i  input  obi_req_t  master 0 request (req, we, be[3:0], addr[31:0], wdata[31:0])
m0_resp_o  output  obi_resp_t  master 0 response (gnt, rvalid, rdata[31:0])
m1_req_i  input  obi_req_t  master 1 request
m1_resp_o  output  obi_resp_t  master 1 response
s_req_o  output  obi_req_t  request to the bus slave
s_resp_i  input  obi_resp_t  response from the bus slave
busy_o  output  1  high while at least one transaction is outstanding
err_o  output  1  sticky protocol error: rvalid received with an empty FIFO

Behaviour:
- Reset (async, rst_ni=0):
  - Route FIFO empty, outstanding count=0.
  - Round-robin pointer prefers m0.
  - lock=0, err_o=0.
  - All outputs deassert combinationally from the reset state: s_req_o.req=0 when no master requests, rvalid=0 on both masters, busy_o=0.
- full = (count == MAX_OUTSTANDING).
- Selection (combinational), when lock=0:
  - Only one master requests: select that master.
  - Both request, ROUND_ROBIN=1: select the master the pointer prefers.
  - Both request, ROUND_ROBIN=0: select m0.
- Lock:
  - Set when s_req_o.req=1 and s_resp_i.gnt=0. Lock_idx stores the selected master.
  - While lock=1, selection is forced to lock_idx regardless of the other master.
  - Cleared on the cycle s_resp_i.gnt=1.
  - This keeps the slave-side address phase stable per OBI.
- Slave request:
  - s_req_o.req = selected master's req AND !full.
  - s_req_o.{we,be,addr,wdata} = selected master's fields. All zeros when no master is selected.
- Grant:
  - mX_resp_o.gnt = s_resp_i.gnt AND s_req_o.req AND (selected==X).
  - The non-selected master's gnt is 0.
- Handshake (s_req_o.req & s_resp_i.gnt):
  - Push the selected index into the FIFO; count+1.
  - If ROUND_ROBIN=1, the pointer moves to prefer the other master.
- Response:
  - On s_resp_i.rvalid with FIFO non-empty: pop the head; count-1.
  - mX_resp_o.rvalid = rvalid AND (head==X).
  - mX_resp_o.rdata = s_resp_i.rdata when head==X, else 0.
  - No added latency.
- Push and pop in the same cycle: count unchanged. Push writes to the tail, pop reads the old head.
- full:
  - No new request is presented; m0/m1 gnt stay 0.
  - A pop in the same cycle does not enable a grant (no bypass); the grant can occur the next cycle.
  - Lock cannot be active while full, because count only increments on gnt.
- rvalid with FIFO empty: discarded, no master sees rvalid, err_o set to 1. err_o holds until reset.
- Pointers wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING+1).
- busy_o = (count != 0), registered-state derived.
- Reset mid-transaction: the FIFO is flushed; responses arriving after reset raise err_o.

Test Plan:
1. Single master: m0 issues a read to 0x0000_1000, slave gnt in the same cycle, rvalid 1 cycle later with rdata 0xDEADBEEF. Required: m0 gnt the same cycle, m0 rvalid+rdata=0xDEADBEEF, m1 rvalid=0, busy_o 1 for exactly 1 cycle.
2. Contention, ROUND_ROBIN=1: both masters request continuously with slave gnt=1 every cycle. Required: grants alternate m0,m1,m0,m1 and responses route in issue order.
3. Lock: m1 selected, slave holds gnt=0 for 3 cycles while m0 also requests. Required: s_req_o.addr stays at m1's address all 3 cycles, m1 granted on cycle 4, then m0 granted.
4. Full, MAX_OUTSTANDING=2: two grants issued with no rvalid. Required: s_req_o.req=0 and third request not granted. On rvalid (pop), the grant occurs the following cycle, not the same cycle.
5. Simultaneous push/pop: count=1, gnt and rvalid in the same cycle. Required: count stays 1, old head routed correctly, new id queued.
6. Spurious rvalid with count=0. Required: no master rvalid, err_o=1 and stays 1 until rst_ni=0, which clears it to 0.
